// File: rtl/snake_collision_if.sv
// snake_collision_if: request/result bundle between the tick logic and the collision scheduler
//   master: drives start, snake1/snake2 bodies, len1/len2; receives busy, done, hit1, hit2, head_on
//   slave:  the scheduler side of the same signals
interface snake_collision_if #(
  parameter int SEGS  = 16,
  parameter int POS_W = 10
);
  logic                       start;
  logic [SEGS-1:0][POS_W-1:0] snake1;
  logic [SEGS-1:0][POS_W-1:0] snake2;
  logic [4:0]                 len1;
  logic [4:0]                 len2;
  logic                       busy;
  logic                       done;
  logic                       hit1;
  logic                       hit2;
  logic                       head_on;
  modport master (
    output start, snake1, snake2, len1, len2,
    input  busy, done, hit1, hit2, head_on
  );
  modport slave (
    input  start, snake1, snake2, len1, len2,
    output busy, done, hit1, hit2, head_on
  );
endinterface

// File: rtl/snake_collision_sched.sv
// snake_collision_sched: per-tick collision check of two snakes using one shared compare datapath
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of snake_collision_if (start/bodies/lengths in, busy/done/hits out)
module snake_collision_sched #(
  parameter int SEGS  = 16,
  parameter int POS_W = 10,
  parameter int MAX_X = 29,
  parameter int MAX_Y = 23
) (
  input logic               clk,
  input logic               rst,
  snake_collision_if.slave  bus
);
  localparam int IW = $clog2(SEGS);
  localparam int YW = POS_W / 2;
  localparam int XW = POS_W - YW;
  localparam logic [XW-1:0] MX = XW'(MAX_X);
  localparam logic [YW-1:0] MY = YW'(MAX_Y);
  typedef enum logic [1:0] {IDLE, WALL, SCAN, DONE} state_t;
  state_t                     state_q, state_d;
  logic [SEGS-1:0][POS_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [4:0]                 l1_q, l1_d, l2_q, l2_d;
  logic [IW-1:0]              i_q, i_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic                       hit1_q, hit1_d, hit2_q, hit2_d, ho_q, ho_d;
  logic [POS_W-1:0]           h1, h2;
  logic                       wall1, wall2, heq, c11, c12, c21, c22, last;
  logic [4:0]                 iw;
  function automatic logic [4:0] clamp(input logic [4:0] l);
    return l == 5'd0 ? 5'd1 : l > 5'(SEGS) ? 5'(SEGS) : l;
  endfunction
  assign h1    = s1_q[0];
  assign h2    = s2_q[0];
  assign iw    = 5'(i_q);
  assign wall1 = h1[POS_W-1:YW] > MX || h1[YW-1:0] > MY;
  assign wall2 = h2[POS_W-1:YW] > MX || h2[YW-1:0] > MY;
  assign heq   = h1 == h2;
  // index 0 is excluded from the self terms: a head always equals itself
  assign c12 = iw < l2_q && h1 == s2_q[i_q];
  assign c11 = i_q != '0 && iw < l1_q && h1 == s1_q[i_q];
  assign c21 = iw < l1_q && h2 == s1_q[i_q];
  assign c22 = i_q != '0 && iw < l2_q && h2 == s2_q[i_q];
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    i_d     = i_q;
    hit1_d  = hit1_q;
    hit2_d  = hit2_q;
    ho_d    = ho_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        s1_d    = bus.snake1;
        s2_d    = bus.snake2;
        l1_d    = clamp(bus.len1);
        l2_d    = clamp(bus.len2);
        i_d     = '0;
        hit1_d  = 1'b0;
        hit2_d  = 1'b0;
        ho_d    = 1'b0;
        busy_d  = 1'b1;
        state_d = WALL;
      end
      WALL: begin
        hit1_d  = wall1 || heq;
        hit2_d  = wall2 || heq;
        ho_d    = heq;
        last    = hit1_d && hit2_d;
        busy_d  = !last;
        done_d  = last;
        state_d = last ? DONE : SCAN;
      end
      SCAN: begin
        hit1_d  = hit1_q || c12 || c11;
        hit2_d  = hit2_q || c21 || c22;
        last    = (hit1_d && hit2_d) || i_q == IW'(SEGS - 1);
        i_d     = i_q + IW'(1);
        busy_d  = !last;
        done_d  = last;
        state_d = last ? DONE : SCAN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      ho_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
      ho_q    <= ho_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
    end
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit1    = hit1_q;
  assign bus.hit2    = hit2_q;
  assign bus.head_on = ho_q;
endmodule

// File: doc/snake_collision_sched.md
# snake_collision_sched

Time-multiplexed collision controller for the two-snake game. On each game tick it snapshots both snake bodies, then sequences a single head-vs-segment compare datapath across all segment indices, one index per cycle, plus wall and head-on checks. It sits between the game-tick generator (`start`) and the snake-move/game-over logic, which consumes `hit1`/`hit2` on `done`.

## Interface
- `SEGS`, 16: segments per snake; index 0 is the head.
- `POS_W`, 10: position width; x = `[POS_W-1:POS_W/2]`, y = `[POS_W/2-1:0]`.
- `MAX_X`, 29: largest legal x; a head with x > `MAX_X` is a wall hit.
- `MAX_Y`, 23: largest legal y; a head with y > `MAX_Y` is a wall hit.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a check; accepted only in IDLE.
- `snake1` in `[SEGS-1:0][POS_W-1:0]`: snake 1 segment positions.
- `snake2` in `[SEGS-1:0][POS_W-1:0]`: snake 2 segment positions.
- `len1` in 5: snake 1 valid segment count.
- `len2` in 5: snake 2 valid segment count.
- `busy` out 1: high while WALL or SCAN is active.
- `done` out 1: 1-cycle pulse when the results are valid.
- `hit1` out 1: snake 1 head collided (wall, self, other, or head-on).
- `hit2` out 1: snake 2 head collided.
- `head_on` out 1: the two heads share the same position.

## Operation
- States: IDLE, WALL, SCAN, DONE.
- **IDLE**
  - On `start`: register `snake1`, `snake2`, `len1`, `len2` into snapshot registers.
  - Clear `hit1`, `hit2`, `head_on`; set index `i` = 0; go to WALL.
  - Inputs may change freely after acceptance.
- **Length rule** (applied at snapshot): length 0 is treated as 1; length > `SEGS` is clamped to `SEGS`. Effective lengths are L1 and L2.
- **WALL** (one cycle)
  - Set `hit1` if the snake 1 head x > `MAX_X` or y > `MAX_Y`; same rule for `hit2` with the snake 2 head.
  - If the heads are equal, set `head_on`, `hit1` and `hit2`.
  - Next state is DONE if both hits are now set, else SCAN.
- **SCAN** (one index `i` per cycle, `i` = 0..SEGS-1)
  - `hit1` |= (i < L2) && head1 == s2[i].
  - `hit1` |= (1 ≤ i < L1) && head1 == s1[i] (self collision).
  - `hit2` |= (i < L1) && head2 == s1[i].
  - `hit2` |= (1 ≤ i < L2) && head2 == s2[i].
  - Go to DONE after `i` = SEGS-1, or as soon as `hit1` && `hit2` (early exit).
  - Segments at or beyond the effective length never cause a hit, whatever their value.
- **DONE** (one cycle): assert `done`, then go to IDLE. A `start` seen in DONE is ignored.
- `start` is ignored while in WALL, SCAN or DONE. Requests are dropped, not queued.
- Hit flags are sticky: they hold from DONE until the next accepted `start`.
- **Reset**
  - All outputs are 0: `busy`=0, `done`=0, `hit1`=0, `hit2`=0, `head_on`=0.
  - State returns to IDLE and `i` = 0.
  - A reset in mid-operation aborts the check; no `done` is produced.

## Timing
- Cycle 0: `start` is high in IDLE and is sampled at the edge.
- Cycle 1: WALL; `busy`=1.
- Cycles 2..SEGS+1: SCAN; `busy`=1.
- Cycle SEGS+2 (18 at default): DONE; `done`=1, `busy`=0, hits valid.
- Cycle SEGS+3: IDLE; the earliest cycle a new `start` is accepted.
- Early exit in WALL gives `done` at cycle 2.
- Early exit after scanning index k (hits set in cycle 2+k) gives `done` at cycle 3+k.
- Hit flags update on the edge ending each WALL/SCAN cycle and are stable throughout the `done` cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Clear board:** snake1 head (5,5) with L1=4; snake2 head (20,10) with L2=4; no overlaps -> `done` at cycle 18, `hit1`=`hit2`=`head_on`=0, `busy` high for cycles 1–17.
- **Other-body hit:** snake1 head equals snake2[3], L2=8 -> `hit1`=1, `hit2`=0, `done` at cycle 18. Repeat with L2=3 -> `hit1`=0, because the index is beyond the length.
- **Head-on:** both heads at (10,10) -> `head_on`=`hit1`=`hit2`=1, early exit, `done` at cycle 2.
- **Wall plus self:** snake1 head x=30 (wall); snake2 head equals snake2[2], L2=5 -> `hit1` set in WALL, `hit2` set in cycle 4, early exit with `done` at cycle 5.
- **Start filtering:** pulse `start` during SCAN and again during DONE -> both ignored, exactly one `done`. A `start` at cycle 19 is accepted and clears the flags at cycle 1 of the new check.
- **Reset mid-scan:** assert `rst` at cycle 8 -> next cycle all outputs 0 and IDLE, no `done`. A following `start` then completes normally in 18 cycles.
